// File: rtl/instr_dispatch_arbiter.sv
// instr_dispatch_arbiter: steers each instruction to one of two lane FIFOs.
// Route priority is forced route, then register dependency, then alternation.
// Ports: clk, resetn (async, active-low), instr -> instr_out, FIFO_1_en, FIFO_2_en.
// Optional ARB_STATS_EN adds fifo1_count/fifo2_count (saturating, 16 bit).
module instr_dispatch_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_out,
  output logic              FIFO_1_en,
  output logic              FIFO_2_en
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       fifo1_count,
  output logic [15:0]       fifo2_count
`endif
);

  logic [1:0]       route;
  logic [REG_W-1:0] src_a;
  logic [REG_W-1:0] src_b;
  logic [REG_W-1:0] dest;

  assign route = instr[28:27];
  assign src_a = instr[16 +: REG_W];
  assign src_b = instr[11 +: REG_W];
  assign dest  = instr[0 +: REG_W];

  // Entry 0 is the newest destination.
  logic [HIST_DEPTH-1:0][REG_W-1:0] hist1;
  logic [HIST_DEPTH-1:0][REG_W-1:0] hist2;
  logic [HIST_DEPTH-1:0]            vld1;
  logic [HIST_DEPTH-1:0]            vld2;

  // 1 when the previous instruction went to FIFO 2.
  logic last2;

  logic hit1;
  logic hit2;
  logic force1;
  logic force2;
  logic dep1;
  logic dep2;
  logic tgt2;

  // r0 is hard-wired zero, so a zero entry never creates a dependency.
  function automatic logic reg_hit(
    input logic [REG_W-1:0] h,
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] b,
    input logic [REG_W-1:0] d
  );
    return (h != '0) && ((h == a) || (h == b) || (h == d));
  endfunction

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (vld1[i] && reg_hit(hist1[i], src_a, src_b, dest))
        hit1 = 1'b1;
      if (vld2[i] && reg_hit(hist2[i], src_a, src_b, dest))
        hit2 = 1'b1;
    end
  end

  assign force1 = (route == 2'b10);
  assign force2 = (route == 2'b11);
  assign dep1   = !route[1] && hit1;
  assign dep2   = !route[1] && !hit1 && hit2;

  always_comb begin
    tgt2 = !last2;
    unique case (1'b1)
      force1:  tgt2 = 1'b0;
      force2:  tgt2 = 1'b1;
      dep1:    tgt2 = 1'b0;
      dep2:    tgt2 = 1'b1;
      default: tgt2 = !last2;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instr_out <= '0;
      FIFO_1_en <= 1'b0;
      FIFO_2_en <= 1'b0;
      hist1     <= '0;
      hist2     <= '0;
      vld1      <= '0;
      vld2      <= '0;
      last2     <= 1'b1;
    end else begin
      instr_out <= instr;
      FIFO_1_en <= !tgt2;
      FIFO_2_en <= tgt2;
      last2     <= tgt2;
      if (tgt2) begin
        hist2[0] <= dest;
        vld2[0]  <= 1'b1;
        for (int i = 1; i < HIST_DEPTH; i++) begin
          hist2[i] <= hist2[i-1];
          vld2[i]  <= vld2[i-1];
        end
      end else begin
        hist1[0] <= dest;
        vld1[0]  <= 1'b1;
        for (int i = 1; i < HIST_DEPTH; i++) begin
          hist1[i] <= hist1[i-1];
          vld1[i]  <= vld1[i-1];
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo1_count <= '0;
      fifo2_count <= '0;
    end else begin
      if (!tgt2 && fifo1_count != 16'hFFFF)
        fifo1_count <= fifo1_count + 16'd1;
      if (tgt2 && fifo2_count != 16'hFFFF)
        fifo2_count <= fifo2_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_dispatch_arbiter.sv
// Scoreboard bench for instr_dispatch_arbiter.
// Directed vectors with hand-computed lanes; monitor pops on each enable.
module tb_instr_dispatch_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] instr = '1;
  logic [31:0] instr_out;
  logic        FIFO_1_en;
  logic        FIFO_2_en;
`ifdef ARB_STATS_EN
  logic [15:0] fifo1_count;
  logic [15:0] fifo2_count;
`endif

  always #5 clk = ~clk;

  instr_dispatch_arbiter dut (
    .clk(clk),
    .resetn(resetn),
    .instr(instr),
    .instr_out(instr_out),
    .FIFO_1_en(FIFO_1_en),
    .FIFO_2_en(FIFO_2_en)
`ifdef ARB_STATS_EN
    ,
    .fifo1_count(fifo1_count),
    .fifo2_count(fifo2_count)
`endif
  );

  typedef struct packed {
    logic        en1;
    logic        en2;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   c1 = 0;
  int   c2 = 0;

  function automatic logic [31:0] mk(
    input logic [2:0] op,
    input logic [1:0] rt,
    input logic [4:0] sa,
    input logic [4:0] sb,
    input logic [4:0] d
  );
    return {op, rt, 6'b0, sa, sb, 6'b0, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one instruction; t is the hand-computed target lane.
  task automatic send(input logic [31:0] x, input int t);
    exp_t e;
    @(negedge clk);
    instr  = x;
    resetn = 1'b1;
    e.en1  = (t == 1);
    e.en2  = (t == 2);
    e.data = x;
    q.push_back(e);
    if (t == 1) c1++;
    else c2++;
  endtask

  // Assert reset between edges, after the last output was consumed.
  task automatic mid_reset(input string name);
    @(negedge clk);
    #2;
    check({name, "_drained"}, 64'(q.size()), 64'd0);
`ifdef ARB_STATS_EN
    check({name, "_cnt1_pre"}, 64'(fifo1_count), 64'(c1));
    check({name, "_cnt2_pre"}, 64'(fifo2_count), 64'(c2));
`endif
    resetn = 1'b0;
    #1;
    check({name, "_en"}, {62'd0, FIFO_1_en, FIFO_2_en}, 64'd0);
    check({name, "_out"}, 64'(instr_out), 64'd0);
`ifdef ARB_STATS_EN
    check({name, "_cnt1"}, 64'(fifo1_count), 64'd0);
    check({name, "_cnt2"}, 64'(fifo2_count), 64'd0);
`endif
    c1 = 0;
    c2 = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (FIFO_1_en || FIFO_2_en) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: en=%b%b out=%h, required none",
                   FIFO_1_en, FIFO_2_en, instr_out);
        end else begin
          e = q.pop_front();
          if (FIFO_1_en !== e.en1 || FIFO_2_en !== e.en2 ||
              instr_out !== e.data) begin
            fails++;
            $display("FAIL route: got en=%b%b out=%h, required en=%b%b out=%h",
                     FIFO_1_en, FIFO_2_en, instr_out, e.en1, e.en2, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    resetn = 1'b0;
    instr  = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", {62'd0, FIFO_1_en, FIFO_2_en}, 64'd0);
    check("rst_out", 64'(instr_out), 64'd0);
`ifdef ARB_STATS_EN
    check("rst_cnt1", 64'(fifo1_count), 64'd0);
    check("rst_cnt2", 64'(fifo2_count), 64'd0);
`endif
    // First auto instruction after reset.
    send(32'h00045678, 1);
    // Forced routes, the third also depends on FIFO 1 history.
    send(mk(3'b101, 2'b10, 5'd0, 5'd0, 5'd1), 1);
    send(mk(3'b101, 2'b10, 5'd0, 5'd0, 5'd3), 1);
    send(mk(3'b010, 2'b11, 5'd3, 5'd1, 5'd7), 2);
    send(mk(3'b010, 2'b11, 5'd1, 5'd0, 5'd15), 2);
    // Dependency chain A..D.
    send(mk(3'b000, 2'b00, 5'd16, 5'd17, 5'd21), 1);
    send(mk(3'b000, 2'b00, 5'd0, 5'd21, 5'd20), 1);
    send(mk(3'b000, 2'b00, 5'd0, 5'd21, 5'd23), 1);
    send(mk(3'b000, 2'b00, 5'd0, 5'd21, 5'd1), 2);
    // Alternation, route 01 is also auto.
    send(mk(3'b001, 2'b00, 5'd2, 5'd4, 5'd5), 1);
    send(mk(3'b001, 2'b01, 5'd6, 5'd8, 5'd9), 2);
    send(mk(3'b001, 2'b00, 5'd10, 5'd11, 5'd12), 1);
    send(mk(3'b001, 2'b01, 5'd13, 5'd14, 5'd16), 2);
    send(mk(3'b001, 2'b00, 5'd17, 5'd18, 5'd19), 1);
    send(mk(3'b001, 2'b00, 5'd22, 5'd24, 5'd25), 2);
    // Register 0 never matches, even once r0 sits in history.
    send(mk(3'b000, 2'b00, 5'd0, 5'd0, 5'd0), 1);
    send(mk(3'b111, 2'b00, 5'd0, 5'd0, 5'd0), 2);
    // Both histories match: FIFO 1 wins.
    send(mk(3'b000, 2'b00, 5'd25, 5'd19, 5'd26), 1);
    // FIFO 2 dependencies, the second against alternation.
    send(mk(3'b000, 2'b00, 5'd25, 5'd0, 5'd27), 2);
    send(mk(3'b000, 2'b00, 5'd27, 5'd0, 5'd28), 2);
    send(mk(3'b000, 2'b00, 5'd28, 5'd0, 5'd29), 2);
    mid_reset("mid");
    // History cleared: r29 and r28 no longer pull toward FIFO 2.
    send(mk(3'b000, 2'b00, 5'd29, 5'd28, 5'd30), 1);
    send(mk(3'b000, 2'b00, 5'd3, 5'd4, 5'd5), 2);
    mid_reset("end");
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
